// File: rtl/uart_receiver_if.sv
// Serial input plus byte-output handshake for the UART receiver.
// The receiver takes the master view; the consumer/driver takes the slave view.
interface uart_receiver_if;
    logic       s_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        input  s_in,
        input  data_out_ready,
        output data_out,
        output data_out_valid
    );

    modport slave (
        output s_in,
        output data_out_ready,
        input  data_out,
        input  data_out_valid
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronized serial input, mid-bit sampling, one-entry
// output register that newer bytes overwrite; reception never stalls.
module uart_receiver #(
    parameter int unsigned ClockFreq = 100_000_000,
    parameter int unsigned BaudRate  = 115_200
) (
    input  logic             clk,
    input  logic             rst,
    uart_receiver_if.master  rx_if
);
    localparam int unsigned BitTime    = ClockFreq / BaudRate;
    localparam int unsigned SampleTime = BitTime / 2;
    localparam int unsigned CntW       = (BitTime > 1) ? $clog2(BitTime) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(BitTime - 1);
    localparam logic [CntW-1:0] CntSample = CntW'(SampleTime);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]      sync_q, sync_d;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            rx;
    logic            tick;

    assign rx   = sync_q[1];
    assign tick = (cnt_q == CntLast);

    always_comb begin
        sync_d  = {sync_q[0], rx_if.s_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;

        // Consumer accept first; a byte completing this cycle overrides it below.
        if (valid_q && rx_if.data_out_ready)
            valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = START;
                    cnt_d   = CntW'(1);
                end
            end
            START: begin
                cnt_d = cnt_q + CntW'(1);
                // Restarting here puts every later tick one bit-time on, i.e. mid-bit.
                if (cnt_q >= CntSample) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = tick ? '0 : cnt_q + CntW'(1);
                if (tick) begin
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = tick ? '0 : cnt_q + CntW'(1);
                if (tick) begin
                    state_d = IDLE;
                    if (rx) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, good frames
// queue their byte, and a monitor pops one entry per byte the DUT presents.
module tb_uart_receiver;
    localparam int CF     = 4_100_000;
    localparam int BR     = 100_000;
    localparam int BIT    = CF / BR;
    localparam int SAMPLE = BIT / 2;

    typedef struct {
        logic [7:0] b;
        int         stop_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;
    exp_t q[$];

    uart_receiver_if bus();

    uart_receiver #(.ClockFreq(CF), .BaudRate(BR)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.data_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
        bus.s_in = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.s_in = b[i];
            wait_cycles(BIT);
        end
        bus.s_in = stop_bit;
        if (push) q.push_back('{b, cyc});
        wait_cycles(BIT);
    endtask

    task automatic pulse_ready();
        bus.data_out_ready = 1'b1;
        step();
        bus.data_out_ready = 1'b0;
    endtask

    task automatic monitor();
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = '0;
        logic       v;
        logic       r;
        logic [7:0] d;
        exp_t       e;
        int         lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pr = 1'b0; pd = '0;
            end else begin
                v = bus.data_out_valid;
                d = bus.data_out;
                r = bus.data_out_ready;
                if (pv && pr) begin
                    checks++;
                    if (v && d == pd) begin
                        errors++;
                        $display("FAIL hold_after_accept: valid=%0b data=%02h, expected valid=0", v, d);
                    end
                end
                if (v && (!pv || d != pd)) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %02h, expected no output", d);
                    end else begin
                        e   = q.pop_front();
                        lat = cyc - e.stop_cyc;
                        if (d != e.b || lat < SAMPLE || lat > SAMPLE + 3) begin
                            errors++;
                            $display("FAIL rx_byte: got %02h latency %0d, expected %02h latency %0d..%0d",
                                     d, lat, e.b, SAMPLE, SAMPLE + 3);
                        end
                    end
                end
                pv = v; pd = d; pr = r;
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         bad;
        bus.s_in           = 1'b1;
        bus.data_out_ready = 1'b0;
        fork monitor(); join_none

        wait_cycles(3);
        chk("reset_valid", int'(bus.data_out_valid), 0);
        chk("reset_data", int'(bus.data_out), 0);
        rst = 1'b0;
        wait_cycles(5);

        // Single frame held until consumed
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_cycles(2 * BIT);
        chk("a5_valid_held", int'(bus.data_out_valid), 1);
        chk("a5_data_held", int'(bus.data_out), 'hA5);
        pulse_ready();
        chk("a5_valid_cleared", int'(bus.data_out_valid), 0);

        // Short low glitch is rejected, next frame still received
        bus.s_in = 1'b0;
        wait_cycles(SAMPLE / 2);
        bus.s_in = 1'b1;
        wait_cycles(2 * BIT);
        chk("glitch_no_valid", int'(bus.data_out_valid), 0);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_cycles(2 * BIT);
        chk("3c_data", int'(bus.data_out), 'h3C);
        pulse_ready();

        // Framing error discards the byte
        send_frame(8'h55, 1'b0, 1'b0);
        bus.s_in = 1'b1;
        wait_cycles(2 * BIT);
        chk("framing_valid", int'(bus.data_out_valid), 0);
        chk("framing_data", int'(bus.data_out), 'h3C);

        // Back-to-back frames overwrite the unconsumed byte
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_cycles(2 * BIT);
        chk("overrun_valid", int'(bus.data_out_valid), 1);
        chk("overrun_data", int'(bus.data_out), 'hFF);
        pulse_ready();

        // Reset during data bit 4 of 8'hF0 aborts it
        bus.s_in = 1'b0;
        wait_cycles(5 * BIT);
        bus.s_in = 1'b1;
        wait_cycles(SAMPLE);
        rst = 1'b1;
        #1;
        chk("midreset_valid", int'(bus.data_out_valid), 0);
        chk("midreset_data", int'(bus.data_out), 0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5 * BIT);
        chk("after_abort_valid", int'(bus.data_out_valid), 0);
        send_frame(8'h81, 1'b1, 1'b1);
        wait_cycles(2 * BIT);
        chk("81_data", int'(bus.data_out), 'h81);
        pulse_ready();

        // Ready held high: one-cycle pulse per byte
        bus.data_out_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        wait_cycles(2 * BIT);
        chk("ready_high_valid", int'(bus.data_out_valid), 0);
        bus.data_out_ready = 1'b0;

        // Random bytes, gaps, framing errors and consumer back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, !bad, !bad);
            bus.s_in = 1'b1;
            wait_cycles(bad ? 2 * BIT + $urandom_range(0, BIT) : $urandom_range(0, 2 * BIT));
        end
        wait_cycles(3 * BIT);
        rand_ready = 1'b0;
        bus.data_out_ready = 1'b0;
        chk("missing_bytes", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
